cp0_unit: RTL and testbench

Parametrised CP0 system-control register file for the multi-issue pipeline; successor to the dual-slot CP0 block. It holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId, Config and EBase, takes precise exceptions from any of ISSUE_W commit slots, and runs a programmable-divider timer. It drives a registered-state interrupt request and the exception vector back to the commit stage.

---
 rtl/cp0_pkg.sv | 40 ++++
 rtl/cp0_if.sv | 14 +
 rtl/cp0_timer.sv | 63 ++++++
 rtl/cp0_unit.sv | 168 ++++++++++++++++
 tb/tb_cp0_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses/selects, ExcCodes, field positions, reset words.
// Pure constants and a cause-word packing helper; no state, no latency.
package cp0_pkg;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_EBASE    = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    localparam logic [2:0] SEL_0 = 3'd0;
    localparam logic [2:0] SEL_1 = 3'd1;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_ERET = 5'h1F;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] CONFIG_RESET = 32'h0000_8000;
    localparam logic [31:0] EXC_OFFSET   = 32'h0000_0180;

    function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                               input logic [7:0] ip, input logic [4:0] exc);
        logic [31:0] w;
        w           = '0;
        w[CAUSE_BD] = bd;
        w[CAUSE_TI] = ti;
        w[15:8]     = ip;
        w[6:2]      = exc;
        return w;
    endfunction
endpackage

// File: rtl/cp0_if.sv
// MTC0/MFC0 access bus between the pipeline (master) and the CP0 register file (slave).
// Writes take effect at the next edge; reads are combinational; always ready, no backpressure.
interface cp0_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [2:0]  wsel_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [2:0]  rsel_i;
    logic [31:0] data_o;

    modport master (output we_i, waddr_i, wsel_i, data_i, raddr_i, rsel_i, input data_o);
    modport slave  (input we_i, waddr_i, wsel_i, data_i, raddr_i, rsel_i, output data_o);
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with a COUNT_DIV clock divider and sticky compare-match interrupt.
// Writes land at the next edge; match raises timer_int_o one cycle later; no backpressure.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             timer_q, timer_d;

    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        timer_d   = timer_q;
        if (div_q == DIV_LAST) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (count_q == compare_q) timer_d = 1'b1;
        // A Count write restarts the divider so the new value holds a full period.
        if (count_we_i) begin
            count_d = wdata_i;
            div_d   = '0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            timer_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;
endmodule

// File: rtl/cp0_unit.sv
// CP0 register file: MTC0/MFC0, precise exceptions from ISSUE_W slots, timer, interrupt request.
// State updates one edge after inputs; int_req_o is combinational from registered state; no backpressure.
module cp0_unit import cp0_pkg::*; #(
    parameter int          ISSUE_W     = 2,
    parameter int          HW_INT_N    = 6,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] PRID_VAL    = 32'h0001_8003,
    parameter logic [31:0] RESET_EBASE = 32'h8000_0000,
    localparam int         SLOT_W      = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_if.slave                  bus,
    input  logic [HW_INT_N-1:0]   int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [SLOT_W-1:0]     exc_slot_i,
    input  logic [32*ISSUE_W-1:0] slot_pc_i,
    input  logic [ISSUE_W-1:0]    slot_bd_i,
    input  logic                  badvaddr_we_i,
    input  logic [31:0]           badvaddr_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           ebase_o,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           badvaddr_o,
    output logic                  timer_int_o,
    output logic                  int_req_o,
    output logic [31:0]           exc_vector_o
);
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [17:0] ebase_q, ebase_d;
    logic [31:0] exc_pc, rdata;
    logic        exc_bd, wr0, count_we, compare_we;

    assign wr0        = bus.we_i && (bus.wsel_i == SEL_0);
    assign count_we   = wr0 && (bus.waddr_i == CP0_COUNT);
    assign compare_we = wr0 && (bus.waddr_i == CP0_COMPARE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wdata_i      (bus.data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    always_comb begin
        exc_pc = '0;
        exc_bd = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (exc_slot_i == SLOT_W'(k)) begin
                exc_pc = slot_pc_i[32*k +: 32];
                exc_bd = slot_bd_i[k];
            end
        end
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        ip_sw_d    = ip_sw_q;
        bd_d       = bd_q;
        exc_d      = exc_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ebase_d    = ebase_q;
        ip_hw_d    = 6'(int_i);
        ip_hw_d[5] = ip_hw_d[5] | timer_int_o;

        if (wr0 && bus.waddr_i == CP0_STATUS) begin
            im_d  = bus.data_i[15:8];
            exl_d = bus.data_i[STATUS_EXL];
            ie_d  = bus.data_i[STATUS_IE];
        end
        if (wr0 && bus.waddr_i == CP0_CAUSE) ip_sw_d = bus.data_i[9:8];
        if (wr0 && bus.waddr_i == CP0_EPC)   epc_d   = bus.data_i;
        if (bus.we_i && bus.wsel_i == SEL_1 && bus.waddr_i == CP0_EBASE)
            ebase_d = bus.data_i[29:12];

        // Exception/ERET come last so they win over an MTC0 to the same field.
        if (exc_valid_i) begin
            if (exc_code_i == EXC_ERET) begin
                exl_d = 1'b0;
            end else begin
                if (!exl_q) begin
                    epc_d = exc_pc - {29'd0, exc_bd, 2'b00};
                    bd_d  = exc_bd;
                end
                exl_d = 1'b1;
                exc_d = exc_code_i;
                if (badvaddr_we_i) badvaddr_d = badvaddr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            bd_q       <= 1'b0;
            exc_q      <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            ebase_q    <= RESET_EBASE[29:12];
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            bd_q       <= bd_d;
            exc_q      <= exc_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            ebase_q    <= ebase_d;
        end
    end

    always_comb begin
        status_o             = STATUS_RESET;
        status_o[15:8]       = im_q;
        status_o[STATUS_EXL] = exl_q;
        status_o[STATUS_IE]  = ie_q;
    end

    assign cause_o      = pack_cause(bd_q, timer_int_o, {ip_hw_q, ip_sw_q}, exc_q);
    assign epc_o        = epc_q;
    assign badvaddr_o   = badvaddr_q;
    assign ebase_o      = {2'b10, ebase_q, 12'h000};
    assign exc_vector_o = ebase_o + EXC_OFFSET;
    assign int_req_o    = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

    always_comb begin
        rdata = '0;
        if (bus.rsel_i == SEL_0) begin
            case (bus.raddr_i)
                CP0_BADVADDR: rdata = badvaddr_o;
                CP0_COUNT:    rdata = count_o;
                CP0_COMPARE:  rdata = compare_o;
                CP0_STATUS:   rdata = status_o;
                CP0_CAUSE:    rdata = cause_o;
                CP0_EPC:      rdata = epc_o;
                CP0_PRID:     rdata = PRID_VAL;
                CP0_CONFIG:   rdata = CONFIG_RESET;
                default:      rdata = '0;
            endcase
        end else if (bus.rsel_i == SEL_1 && bus.raddr_i == CP0_EBASE) begin
            rdata = ebase_o;
        end
    end

    assign bus.data_o = rdata;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit; expectations are queued per cycle and checked by a negedge monitor.
module tb_cp0_unit;
    import cp0_pkg::*;

    localparam int W_DATA = 0, W_STATUS = 1, W_CAUSE = 2, W_EPC = 3, W_COUNT = 4, W_COMPARE = 5;
    localparam int W_BADV = 6, W_TIMER = 7, W_INTREQ = 8, W_VEC = 9, W_EBASE = 10;

    logic        clk, rst;
    logic [5:0]  int_i;
    logic        exc_valid_i, badvaddr_we_i, timer_int_o, int_req_o;
    logic [4:0]  exc_code_i;
    logic [0:0]  exc_slot_i;
    logic [63:0] slot_pc_i;
    logic [1:0]  slot_bd_i;
    logic [31:0] badvaddr_i, status_o, cause_o, epc_o, ebase_o, count_o, compare_o, badvaddr_o, exc_vector_o;

    cp0_if bus();

    cp0_unit #(.ISSUE_W(2), .HW_INT_N(6), .COUNT_DIV(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .int_i(int_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_slot_i(exc_slot_i),
        .slot_pc_i(slot_pc_i), .slot_bd_i(slot_bd_i),
        .badvaddr_we_i(badvaddr_we_i), .badvaddr_i(badvaddr_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o),
        .count_o(count_o), .compare_o(compare_o), .badvaddr_o(badvaddr_o),
        .timer_int_o(timer_int_o), .int_req_o(int_req_o), .exc_vector_o(exc_vector_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string       q_name[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur      = -2;

    function automatic logic [31:0] dut_val(input int w);
        case (w)
            W_DATA:    return bus.data_o;
            W_STATUS:  return status_o;
            W_CAUSE:   return cause_o;
            W_EPC:     return epc_o;
            W_COUNT:   return count_o;
            W_COMPARE: return compare_o;
            W_BADV:    return badvaddr_o;
            W_TIMER:   return 32'(timer_int_o);
            W_INTREQ:  return 32'(int_req_o);
            W_VEC:     return exc_vector_o;
            W_EBASE:   return ebase_o;
            default:   return 32'hXXXX_XXXX;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q_sel.size() > 0) begin
            string       nm;
            int          w;
            logic [31:0] e, a;
            nm = q_name.pop_front();
            w  = q_sel.pop_front();
            e  = q_exp.pop_front();
            a  = dut_val(w);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got %08h expected %08h", nm, cur, a, e);
            end
        end
    end

    task automatic expect_val(input string nm, input int w, input logic [31:0] v);
        q_name.push_back(nm);
        q_sel.push_back(w);
        q_exp.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur++;
        bus.we_i      = 1'b0;
        exc_valid_i   = 1'b0;
        badvaddr_we_i = 1'b0;
    endtask

    task automatic goto_cyc(input int k);
        while (cur < k) step();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wsel_i = s; bus.data_i = d;
    endtask

    task automatic rd(input logic [4:0] a, input logic [2:0] s);
        bus.raddr_i = a; bus.rsel_i = s;
    endtask

    task automatic raise(input logic [4:0] code, input logic [0:0] slot, input logic [63:0] pcs,
                         input logic [1:0] bd, input logic bwe, input logic [31:0] bva);
        exc_valid_i = 1'b1; exc_code_i = code; exc_slot_i = slot; slot_pc_i = pcs;
        slot_bd_i = bd; badvaddr_we_i = bwe; badvaddr_i = bva;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_slot_i = '0;
        slot_pc_i = '0; slot_bd_i = '0; badvaddr_we_i = 1'b0; badvaddr_i = '0;
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.wsel_i = '0; bus.data_i = '0;
        bus.raddr_i = CP0_STATUS; bus.rsel_i = SEL_0;
        goto_cyc(0);
        rst = 1'b0;
        expect_val("rst_count", W_COUNT, 32'h0);
        expect_val("rst_status", W_STATUS, 32'h0040_0000);
        expect_val("rst_cause", W_CAUSE, 32'h0);
        expect_val("rst_epc", W_EPC, 32'h0);
        expect_val("rst_compare", W_COMPARE, 32'h0);
        expect_val("rst_badvaddr", W_BADV, 32'h0);
        expect_val("rst_timer", W_TIMER, 32'h0);
        expect_val("rst_intreq", W_INTREQ, 32'h0);
        expect_val("rst_ebase", W_EBASE, 32'h8000_0000);
        expect_val("rst_vector", W_VEC, 32'h8000_0180);
        expect_val("rst_rd_status", W_DATA, 32'h0040_0000);

        // Count==Compare==0 straight out of reset is a legal match.
        goto_cyc(1);
        expect_val("timer_zero_match", W_TIMER, 32'h1);
        expect_val("cause_ti_only", W_CAUSE, 32'h4000_0000);
        goto_cyc(2);
        expect_val("cause_ip7_zero", W_CAUSE, 32'h4000_8000);
        goto_cyc(10);
        expect_val("count_div2", W_COUNT, 32'd5);
        mtc0(CP0_COMPARE, SEL_0, 32'd3);
        goto_cyc(11);
        expect_val("compare_wr", W_COMPARE, 32'd3);
        expect_val("timer_clr_wr", W_TIMER, 32'h0);
        mtc0(CP0_COUNT, SEL_0, 32'd0);
        goto_cyc(12);
        expect_val("count_wr", W_COUNT, 32'd0);
        expect_val("cause_clear", W_CAUSE, 32'h0);
        rd(CP0_COUNT, SEL_0);
        expect_val("rd_count", W_DATA, 32'd0);
        goto_cyc(18);
        expect_val("count_eq3", W_COUNT, 32'd3);
        expect_val("timer_pre", W_TIMER, 32'h0);
        goto_cyc(19);
        expect_val("timer_set", W_TIMER, 32'h1);
        expect_val("cause_ti_19", W_CAUSE, 32'h4000_0000);
        goto_cyc(20);
        expect_val("cause_ip7_20", W_CAUSE, 32'h4000_8000);
        expect_val("count_20", W_COUNT, 32'd4);
        mtc0(CP0_COMPARE, SEL_0, 32'h100);
        goto_cyc(21);
        expect_val("timer_cleared", W_TIMER, 32'h0);
        rd(CP0_COMPARE, SEL_0);
        expect_val("rd_compare", W_DATA, 32'h100);
        expect_val("cause_ip7_lag", W_CAUSE, 32'h0000_8000);

        goto_cyc(22);
        expect_val("cause_22", W_CAUSE, 32'h0);
        raise(EXC_ADEL, 1'b1, {32'hBFC0_0104, 32'h1111_0000}, 2'b10, 1'b1, 32'h1233);
        goto_cyc(23);
        expect_val("exc1_epc", W_EPC, 32'hBFC0_0100);
        expect_val("exc1_cause", W_CAUSE, 32'h8000_0010);
        expect_val("exc1_status", W_STATUS, 32'h0040_0002);
        expect_val("exc1_badv", W_BADV, 32'h0000_1233);
        rd(CP0_EPC, SEL_0);
        expect_val("exc1_rd_epc", W_DATA, 32'hBFC0_0100);
        raise(EXC_SYS, 1'b0, {32'hBFC0_0104, 32'h2000_0000}, 2'b00, 1'b0, 32'hFFFF_FFFF);
        goto_cyc(24);
        expect_val("exc2_epc_hold", W_EPC, 32'hBFC0_0100);
        expect_val("exc2_cause", W_CAUSE, 32'h8000_0020);
        expect_val("exc2_status", W_STATUS, 32'h0040_0002);
        expect_val("exc2_badv_hold", W_BADV, 32'h0000_1233);
        raise(EXC_ERET, 1'b1, {32'h4444_4444, 32'h5555_5555}, 2'b11, 1'b0, 32'h0);
        goto_cyc(25);
        expect_val("eret_status", W_STATUS, 32'h0040_0000);
        expect_val("eret_cause", W_CAUSE, 32'h8000_0020);
        expect_val("eret_epc", W_EPC, 32'hBFC0_0100);
        mtc0(CP0_STATUS, SEL_0, 32'h0000_0401);

        goto_cyc(26);
        expect_val("status_wr", W_STATUS, 32'h0040_0401);
        expect_val("intreq_idle", W_INTREQ, 32'h0);
        int_i = 6'b000001;
        goto_cyc(27);
        expect_val("intreq_set", W_INTREQ, 32'h1);
        expect_val("cause_ip2", W_CAUSE, 32'h8000_0420);
        mtc0(CP0_STATUS, SEL_0, 32'h0000_0403);
        goto_cyc(28);
        expect_val("intreq_exl", W_INTREQ, 32'h0);
        expect_val("status_exl", W_STATUS, 32'h0040_0403);
        mtc0(CP0_STATUS, SEL_0, 32'h0000_0401);
        goto_cyc(29);
        expect_val("intreq_again", W_INTREQ, 32'h1);
        raise(EXC_ADEL, 1'b0, {32'hBFC0_0104, 32'h3000_0008}, 2'b00, 1'b0, 32'h0);
        mtc0(CP0_STATUS, SEL_0, 32'h0000_0401);
        goto_cyc(30);
        expect_val("exc_over_mtc0", W_STATUS, 32'h0040_0403);
        expect_val("exc3_intreq", W_INTREQ, 32'h0);
        expect_val("exc3_epc", W_EPC, 32'h3000_0008);
        expect_val("exc3_cause", W_CAUSE, 32'h0000_0410);
        int_i = '0;
        raise(EXC_ERET, 1'b0, {32'h0, 32'h0}, 2'b00, 1'b0, 32'h0);
        mtc0(CP0_STATUS, SEL_0, 32'h0000_0403);
        goto_cyc(31);
        expect_val("eret_over_mtc0", W_STATUS, 32'h0040_0401);
        expect_val("cause_31", W_CAUSE, 32'h0000_0010);
        expect_val("intreq_31", W_INTREQ, 32'h0);
        mtc0(CP0_EBASE, SEL_1, 32'hFFFF_FFFF);

        goto_cyc(32);
        expect_val("ebase_wr", W_EBASE, 32'hBFFF_F000);
        expect_val("vector_wr", W_VEC, 32'hBFFF_F180);
        rd(CP0_EBASE, SEL_1);
        expect_val("rd_ebase", W_DATA, 32'hBFFF_F000);
        mtc0(CP0_BADVADDR, SEL_0, 32'h0000_DEAD);
        goto_cyc(33);
        expect_val("badv_ro", W_BADV, 32'h0000_1233);
        rd(CP0_PRID, SEL_0);
        expect_val("rd_prid", W_DATA, 32'h0001_8003);
        mtc0(CP0_CAUSE, SEL_0, 32'hFFFF_FFFF);
        goto_cyc(34);
        expect_val("cause_sw_wr", W_CAUSE, 32'h0000_0310);
        rd(CP0_CONFIG, SEL_0);
        expect_val("rd_config", W_DATA, 32'h0000_8000);
        mtc0(CP0_COUNT, SEL_0, 32'hFFFF_FFFF);
        goto_cyc(35);
        expect_val("count_max", W_COUNT, 32'hFFFF_FFFF);
        rd(5'd7, SEL_0);
        expect_val("rd_unmapped", W_DATA, 32'h0);
        goto_cyc(36);
        expect_val("count_div_restart", W_COUNT, 32'hFFFF_FFFF);
        rd(CP0_CAUSE, 3'd2);
        expect_val("rd_bad_sel", W_DATA, 32'h0);
        goto_cyc(37);
        expect_val("count_wrap", W_COUNT, 32'h0);
        rst = 1'b1;
        int_i = 6'h3F;
        mtc0(CP0_STATUS, SEL_0, 32'h0000_0401);
        goto_cyc(38);
        rst = 1'b0;
        int_i = '0;
        expect_val("mid_rst_status", W_STATUS, 32'h0040_0000);
        expect_val("mid_rst_count", W_COUNT, 32'h0);
        expect_val("mid_rst_compare", W_COMPARE, 32'h0);
        expect_val("mid_rst_epc", W_EPC, 32'h0);
        expect_val("mid_rst_cause", W_CAUSE, 32'h0);
        expect_val("mid_rst_badv", W_BADV, 32'h0);
        expect_val("mid_rst_ebase", W_EBASE, 32'h8000_0000);
        expect_val("mid_rst_timer", W_TIMER, 32'h0);
        expect_val("mid_rst_intreq", W_INTREQ, 32'h0);
        step();

        if (q_sel.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
